reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard tracking in-flight destination writes
// Per-register pending-write counters gate issue on RAW hazards and WAW counter saturation.
module reg_scoreboard #(
  parameter int READ_PORTS = 2,
  parameter int WB_PORTS   = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [READ_PORTS-1:0]          rd_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS*ADDR_WIDTH-1:0] wb_addr,
  input  logic                           flush,
  output logic [READ_PORTS-1:0]          hazard_mask,
  output logic [(2**ADDR_WIDTH)-1:0]     busy_vec,
  output logic [31:0]                    stall_cnt,
  output logic                           err_underflow
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;
  // Wide enough to hold cnt + 1 and up to WB_PORTS decrements without wrap.
  localparam int SW = CNT_WIDTH + $clog2(WB_PORTS + 1) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;

  logic [CNT_WIDTH-1:0] cnt      [REG_COUNT];
  logic [CNT_WIDTH-1:0] cnt_next [REG_COUNT];
  logic                 waw_full;
  logic                 fire;
  logic                 underflow_next;
  logic                 stall_now;

  function automatic logic [SW-1:0] dec_count(
    input logic [WB_PORTS-1:0]            valid,
    input logic [WB_PORTS*ADDR_WIDTH-1:0] addrs,
    input logic [ADDR_WIDTH-1:0]          target
  );
    logic [SW-1:0] n;
    n = '0;
    for (int j = 0; j < WB_PORTS; j++) begin
      if (valid[j] && addrs[j*ADDR_WIDTH +: ADDR_WIDTH] == target) begin
        n = n + SW'(1);
      end
    end
    return n;
  endfunction

  always_comb begin
    hazard_mask = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      hazard_mask[i] = rd_en[i]
                       && (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                       && (cnt[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] != '0);
    end
  end

  assign waw_full    = wr_en && (wr_addr != '0) && (cnt[wr_addr] == CNT_FULL);
  assign issue_ready = !(|hazard_mask) && !waw_full && !flush;
  assign fire        = issue_valid && issue_ready;
  assign stall_now   = issue_valid && !issue_ready;

  // Net per-register update: issue increment and all writeback decrements in one edge.
  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] dec;
    underflow_next = 1'b0;
    sum            = '0;
    dec            = '0;
    cnt_next[0]    = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      sum = SW'(cnt[r]);
      if (fire && wr_en && wr_addr == ADDR_WIDTH'(r)) begin
        sum = sum + SW'(1);
      end
      dec = dec_count(wb_valid, wb_addr, ADDR_WIDTH'(r));
      if (dec > sum) begin
        cnt_next[r]    = '0;
        underflow_next = 1'b1;
      end else begin
        cnt_next[r] = CNT_WIDTH'(sum - dec);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt[r] <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt[r] <= flush ? '0 : cnt_next[r];
      end
      if (!flush && underflow_next) begin
        err_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_now && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

endmodule
